// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer:
//   - FSM state encoding (RUN, LU_STALL, MDU_WAIT)
//   - register-number width and counter width
//   - the bundle of pipeline-register controls and helpers that build the
//     canonical control patterns (advance, load-use bubble, MDU freeze,
//     memory wait)
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

   localparam int REG_W = 5;
   localparam int CNT_W = 8;

   localparam logic [CNT_W-1:0] CNT_ZERO = 8'd0;
   localparam logic [CNT_W-1:0] CNT_ONE  = 8'd1;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MDU_WAIT = 2'd2
   } ctrl_state_e;

   typedef struct packed {
      logic pc_en;
      logic en_if_id;
      logic en_id_ex;
      logic en_ex_mem;
      logic en_mem_wb;
      logic flush_if_id;
      logic flush_id_ex;
      logic flush_ex_mem;
      logic flush_mem_wb;
      logic mdu_timeout;
   } ctrl_out_t;

   // Every stage advances, nothing is cleared.
   function automatic ctrl_out_t out_default();
      ctrl_out_t o;
      o = '{pc_en: 1'b1, en_if_id: 1'b1, en_id_ex: 1'b1, en_ex_mem: 1'b1,
            en_mem_wb: 1'b1, flush_if_id: 1'b0, flush_id_ex: 1'b0,
            flush_ex_mem: 1'b0, flush_mem_wb: 1'b0, mdu_timeout: 1'b0};
      return o;
   endfunction

   // Hold PC and IF/ID, push a bubble into ID/EX.
   function automatic ctrl_out_t out_load_use();
      ctrl_out_t o;
      o             = out_default();
      o.pc_en       = 1'b0;
      o.en_if_id    = 1'b0;
      o.flush_id_ex = 1'b1;
      return o;
   endfunction

   // Hold the front end and the EX instruction, bubble into EX/MEM.
   function automatic ctrl_out_t out_mdu_freeze();
      ctrl_out_t o;
      o              = out_default();
      o.pc_en        = 1'b0;
      o.en_if_id     = 1'b0;
      o.en_id_ex     = 1'b0;
      o.flush_ex_mem = 1'b1;
      return o;
   endfunction

   // Hold everything up to EX/MEM, bubble into MEM/WB.
   function automatic ctrl_out_t out_mem_wait();
      ctrl_out_t o;
      o              = out_default();
      o.pc_en        = 1'b0;
      o.en_if_id     = 1'b0;
      o.en_id_ex     = 1'b0;
      o.en_ex_mem    = 1'b0;
      o.flush_mem_wb = 1'b1;
      return o;
   endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// -----------------------------------------------------------------------------
// pipe_hazard_detect
// Purely combinational load-use comparator. Flags when the instruction in EX
// is a register-writing load whose destination (non-zero) is read by the
// instruction in ID.
// Ports:
//   i_id_rs, i_id_rt         ID source register numbers
//   i_id_uses_rs/_rt         ID instruction actually reads rs / rt
//   i_ex_mem_read            EX instruction is a load
//   i_ex_reg_write           EX instruction writes a register
//   i_ex_rd                  EX destination register
//   o_hazard                 load-use hazard present this cycle
// -----------------------------------------------------------------------------
module pipe_hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] i_id_rs,
   input  logic [REG_W-1:0] i_id_rt,
   input  logic             i_id_uses_rs,
   input  logic             i_id_uses_rt,
   input  logic             i_ex_mem_read,
   input  logic             i_ex_reg_write,
   input  logic [REG_W-1:0] i_ex_rd,
   output logic             o_hazard
);

   logic w_rs_match;
   logic w_rt_match;
   logic w_load_dest;

   assign w_rs_match  = i_id_uses_rs & (i_id_rs == i_ex_rd);
   assign w_rt_match  = i_id_uses_rt & (i_id_rt == i_ex_rd);
   // r0 is hard-wired zero, so a load targeting it never creates a dependency.
   assign w_load_dest = i_ex_mem_read & i_ex_reg_write & (i_ex_rd != 5'd0);
   assign o_hazard    = w_load_dest & (w_rs_match | w_rt_match);

endmodule

// File: rtl/pipe_stage_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stage_ctrl
// Central stall/flush sequencer for the five-stage pipeline. Drives the
// enables and clears of IF/ID, ID/EX, EX/MEM, MEM/WB and the PC enable,
// resolving memory waits, taken branches, MDU waits and load-use hazards
// (in that priority) with a three-state FSM.
// Parameters:
//   LOAD_USE_BUBBLES  bubble cycles per load-use hazard (1..7)
//   MDU_MAX_CYCLES    MDU watchdog limit in cycles (2..255)
// Ports:
//   Clk, Rst_n                   clock, asynchronous active-low reset
//   id_rs, id_rt, id_uses_rs/rt  ID-stage operand usage
//   ex_mem_read, ex_reg_write,
//   ex_rd                        EX-stage load destination
//   ex_branch_taken              EX branch resolved taken
//   mdu_start, mdu_done          multiply/divide handshake
//   dmem_req, dmem_ready         data-memory wait handshake
//   pc_en, en_*                  register enables
//   flush_*                      register clears
//   mdu_timeout                  one-cycle watchdog expiry pulse
//   ctrl_state                   current FSM state
// Optional feature macro PIPE_CTRL_PERF_EN adds stall_cycles and flush_count.
// -----------------------------------------------------------------------------
module pipe_stage_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int LOAD_USE_BUBBLES = 1,
   parameter int MDU_MAX_CYCLES   = 40
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic             ex_reg_write,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_branch_taken,
   input  logic             mdu_start,
   input  logic             mdu_done,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             en_if_id,
   output logic             en_id_ex,
   output logic             en_ex_mem,
   output logic             en_mem_wb,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             flush_ex_mem,
   output logic             flush_mem_wb,
   output logic             mdu_timeout,
   output logic [1:0]       ctrl_state
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]      stall_cycles,
   output logic [31:0]      flush_count
`endif
);

   // Counter reload for the remaining bubbles after the first one, and the
   // count value at which the watchdog fires.
   localparam logic [CNT_W-1:0] LU_RELOAD = CNT_W'(LOAD_USE_BUBBLES - 1);
   localparam logic [CNT_W-1:0] MDU_LAST  = CNT_W'(MDU_MAX_CYCLES - 1);

   ctrl_state_e      r_state;
   logic [CNT_W-1:0] r_cnt;

   ctrl_state_e      w_nxt_state;
   logic [CNT_W-1:0] w_nxt_cnt;
   ctrl_out_t        w_out;
   logic             w_hazard;
   logic             w_mem_wait;
   logic             w_branch_flush;

   pipe_hazard_detect u_hazard (
      .i_id_rs        (id_rs),
      .i_id_rt        (id_rt),
      .i_id_uses_rs   (id_uses_rs),
      .i_id_uses_rt   (id_uses_rt),
      .i_ex_mem_read  (ex_mem_read),
      .i_ex_reg_write (ex_reg_write),
      .i_ex_rd        (ex_rd),
      .o_hazard       (w_hazard)
   );

   assign w_mem_wait = dmem_req & ~dmem_ready;

   // Next-state and output decode; a memory wait freezes state and cnt so it
   // simply stretches whatever stall is already in progress.
   always_comb begin
      w_out          = out_default();
      w_nxt_state    = r_state;
      w_nxt_cnt      = r_cnt;
      w_branch_flush = 1'b0;
      if (w_mem_wait) begin
         w_out = out_mem_wait();
      end else begin
         case (r_state)
            RUN: begin
               if (ex_branch_taken) begin
                  w_out.flush_if_id = 1'b1;
                  w_out.flush_id_ex = 1'b1;
                  w_branch_flush    = 1'b1;
               end else if (mdu_start && !mdu_done) begin
                  w_out       = out_mdu_freeze();
                  w_nxt_state = MDU_WAIT;
                  w_nxt_cnt   = CNT_ONE;
               end else if (w_hazard) begin
                  w_out = out_load_use();
                  if (LOAD_USE_BUBBLES > 1) begin
                     w_nxt_state = LU_STALL;
                     w_nxt_cnt   = LU_RELOAD;
                  end else begin
                     w_nxt_state = RUN;
                  end
               end else begin
                  w_nxt_state = RUN;
               end
            end
            LU_STALL: begin
               w_out = out_load_use();
               if (r_cnt == CNT_ONE) begin
                  w_nxt_state = RUN;
                  w_nxt_cnt   = CNT_ZERO;
               end else begin
                  w_nxt_cnt = r_cnt - CNT_ONE;
               end
            end
            MDU_WAIT: begin
               if (mdu_done) begin
                  w_nxt_state = RUN;
                  w_nxt_cnt   = CNT_ZERO;
               end else if (r_cnt == MDU_LAST) begin
                  // Watchdog: release the pipeline as if the result arrived.
                  w_out.mdu_timeout = 1'b1;
                  w_nxt_state       = RUN;
                  w_nxt_cnt         = CNT_ZERO;
               end else begin
                  w_out     = out_mdu_freeze();
                  w_nxt_cnt = r_cnt + CNT_ONE;
               end
            end
            default: begin
               w_nxt_state = RUN;
               w_nxt_cnt   = CNT_ZERO;
            end
         endcase
      end
   end

   // FSM state and counter registers.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state <= RUN;
         r_cnt   <= CNT_ZERO;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
      end
   end

   // Reset overrides the decode asynchronously: hold every register, clear all.
   assign pc_en        = Rst_n & w_out.pc_en;
   assign en_if_id     = Rst_n & w_out.en_if_id;
   assign en_id_ex     = Rst_n & w_out.en_id_ex;
   assign en_ex_mem    = Rst_n & w_out.en_ex_mem;
   assign en_mem_wb    = Rst_n & w_out.en_mem_wb;
   assign flush_if_id  = ~Rst_n | w_out.flush_if_id;
   assign flush_id_ex  = ~Rst_n | w_out.flush_id_ex;
   assign flush_ex_mem = ~Rst_n | w_out.flush_ex_mem;
   assign flush_mem_wb = ~Rst_n | w_out.flush_mem_wb;
   assign mdu_timeout  = Rst_n & w_out.mdu_timeout;
   assign ctrl_state   = r_state;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_count;

   // Performance counters; both wrap naturally at 2^32.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_stall_cycles <= 32'd0;
         r_flush_count  <= 32'd0;
      end else begin
         if (!pc_en) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end else begin
            r_stall_cycles <= r_stall_cycles;
         end
         if (w_branch_flush) begin
            r_flush_count <= r_flush_count + 32'd1;
         end else begin
            r_flush_count <= r_flush_count;
         end
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;
`endif

endmodule

// File: doc/pipe_stage_ctrl.md
# pipe_stage_ctrl

Central stall/flush sequencer for the five-stage pipeline. Drives the write-enable and clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC enable. Resolves four hazard sources with a small FSM:

- load-use bubbles;
- taken-branch flushes;
- multi-cycle multiply/divide waits;
- data-memory wait states.

Sits beside the datapath in the CPU top level.

## Interface
Parameters:
- LOAD_USE_BUBBLES, default 1: bubble cycles inserted per load-use hazard (1..7).
- MDU_MAX_CYCLES, default 40: MDU watchdog limit in cycles (2..255).

Ports:
- Clk  in  1  single clock; FSM on posedge.
- Rst_n  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  5 each  ID-stage source register numbers.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
- ex_mem_read  in  1  EX instruction is a load.
- ex_reg_write  in  1  EX instruction writes a register.
- ex_rd  in  5  EX destination register.
- ex_branch_taken  in  1  EX branch/jump resolved taken.
- mdu_start  in  1  EX issues a multiply/divide.
- mdu_done  in  1  MDU result valid.
- dmem_req  in  1  MEM stage accessing data memory.
- dmem_ready  in  1  data memory completes this cycle.
- pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb  out  1 each  register enables.
- flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb  out  1 each  register clears (bubble insert).
- mdu_timeout  out  1  one-cycle pulse on watchdog expiry.
- ctrl_state  out  2  current FSM state (debug).

## Operation
- States: RUN=0, LU_STALL=1, MDU_WAIT=2. Counter cnt is 8 bits.
- Default outputs: all enables 1, all flushes 0.
- Hazard term: ex_mem_read & ex_reg_write & (ex_rd≠0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- Priority, evaluated every cycle:
  1. Memory wait (dmem_req & !dmem_ready), in any state: pc_en, en_if_id, en_id_ex, en_ex_mem = 0; flush_mem_wb = 1. State and cnt hold.
  2. Branch, in RUN: flush_if_id = 1, flush_id_ex = 1, pc_en = 1. Next state RUN.
  3. MDU start, in RUN with mdu_start & !mdu_done: pc_en, en_if_id, en_id_ex = 0; flush_ex_mem = 1. Next state MDU_WAIT, cnt = 1. If mdu_done is also high, the cycle is treated as a normal advance.
  4. Load-use, in RUN with hazard: pc_en, en_if_id = 0; flush_id_ex = 1. If LOAD_USE_BUBBLES > 1, next state LU_STALL with cnt = LOAD_USE_BUBBLES-1.
- LU_STALL: same outputs as load-use. When cnt==1 go to RUN, otherwise cnt--. Branch and MDU inputs are ignored.
- MDU_WAIT, no mdu_done: same outputs as MDU start; cnt++.
- MDU_WAIT, mdu_done: all enables 1; next state RUN.
- MDU_WAIT watchdog: when cnt == MDU_MAX_CYCLES-1 without mdu_done, pulse mdu_timeout, advance as if done, go to RUN.
- Reset state: RUN, cnt = 0, mdu_timeout = 0, ctrl_state = 0.
- While Rst_n is low, all enables are forced 0 and all flushes forced 1.

## Timing
- Outputs are combinational from registered state/cnt and current inputs. They settle before the negedge on which the pipeline registers sample.
- Load-use: exactly LOAD_USE_BUBBLES consecutive cycles with pc_en = 0.
- Branch: one flush cycle, zero stall.
- MDU: frozen from the start cycle through the cycle before mdu_done. The stages advance in the done cycle.
- Rst_n asserted mid-stall: immediate return to RUN. The first post-reset cycle has default outputs.
- A memory wait inside LU_STALL or MDU_WAIT extends that state by the wait length.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds outputs stall_cycles[31:0] and flush_count[31:0]. Both reset to 0 and wrap modulo 2^32.
  - stall_cycles increments on each cycle with Rst_n high and pc_en = 0.
  - flush_count increments per branch flush.
- PIPE_CTRL_PERF_EN undefined: these ports and registers are absent. All other behaviour is identical.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state encoding (RUN, LU_STALL, MDU_WAIT);
  - the register-number width (5);
  - the cnt width (8).
- Sub-module pipe_hazard_detect: purely combinational load-use comparator producing the hazard term.
- FSM, counters and output decode live in pipe_stage_ctrl.

## Test plan
- Load-use, default parameters: ex_mem_read = 1, ex_reg_write = 1, ex_rd = 5, id_uses_rs = 1, id_rs = 5. Expect one cycle with pc_en = 0, en_if_id = 0, flush_id_ex = 1, then defaults. With ex_rd = 0: no stall.
- LOAD_USE_BUBBLES = 3, same hazard: pc_en = 0 for 3 cycles; ctrl_state goes 0→1→1→0.
- Branch: ex_branch_taken = 1 for one cycle. Expect flush_if_id = 1, flush_id_ex = 1, pc_en = 1. Repeat with a simultaneous hazard: branch outputs win and no stall follows.
- MDU: mdu_start, mdu_done 5 cycles later. Expect 5 frozen cycles with flush_ex_mem = 1, then an advance cycle. With MDU_MAX_CYCLES = 4 and no done: mdu_timeout pulses on the 4th cycle and the FSM returns to RUN.
- Memory wait during MDU_WAIT: dmem_req = 1, dmem_ready = 0 for 3 cycles. Expect flush_mem_wb = 1 and cnt held, so the watchdog is delayed by 3 cycles.
- Rst_n pulsed low in LU_STALL: enables immediately 0, flushes 1. After release: ctrl_state = 0, default outputs. With PIPE_CTRL_PERF_EN: counters read 0.
